// File: rtl/basket_controller.sv
// -----------------------------------------------------------------------------
// basket_controller
//
// Shopping-basket store for the sale terminal. Keeps an ordered list of
// (ProductID, Quantity) entries. Repeat purchases of a product merge into its
// existing entry, an entry can be cancelled by index (later entries shift down
// so the list never has holes), and the whole basket can be cleared.
//
// Optional feature macro: BASKET_TOTAL_EN
//   defined   : a price ROM (price(id) = 5*(id+1)) and a running TotalPrice
//               register, saturating at 4095.
//   undefined : TotalPrice is tied to 0.
//
// Ports
//   CLOCK_50         in   system clock
//   RESET_N          in   asynchronous active-low reset
//   Enable           in   one-cycle add pulse (ProductID/ProductQuantity)
//   ProductID        in   product to add
//   ProductQuantity  in   quantity to add
//   Cancel           in   one-cycle pulse, remove entry CancelIndex
//   CancelIndex      in   entry index to remove
//   Clear            in   one-cycle pulse, empty the basket
//   RdIndex          in   display read index
//   RdProductID      out  entry[RdIndex] ID (0 when RdValid=0)
//   RdQuantity       out  entry[RdIndex] quantity (0 when RdValid=0)
//   RdValid          out  RdIndex < BasketProductNum
//   BasketProductNum out  number of valid entries
//   Busy             out  FSM not idle
//   Full             out  basket holds MAX_ITEMS entries
//   Done             out  one-cycle pulse, operation completed
//   Err              out  one-cycle pulse, command rejected
//   Sat              out  pulse with Done when a merge clipped the quantity
//   TotalPrice       out  running basket total (0 without BASKET_TOTAL_EN)
// -----------------------------------------------------------------------------
module basket_controller #(
    parameter int MAX_ITEMS = 8,
    parameter int ID_W      = 4,
    parameter int QTY_W     = 4
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             Enable,
    input  logic [ID_W-1:0]  ProductID,
    input  logic [QTY_W-1:0] ProductQuantity,
    input  logic             Cancel,
    input  logic [3:0]       CancelIndex,
    input  logic             Clear,
    input  logic [3:0]       RdIndex,
    output logic [ID_W-1:0]  RdProductID,
    output logic [QTY_W-1:0] RdQuantity,
    output logic             RdValid,
    output logic [3:0]       BasketProductNum,
    output logic             Busy,
    output logic             Full,
    output logic             Done,
    output logic             Err,
    output logic             Sat,
    output logic [11:0]      TotalPrice
);

    localparam logic [3:0]       MAX_CNT = 4'(MAX_ITEMS);
    localparam logic [QTY_W-1:0] QTY_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEARCH  = 3'd1,
        S_WRITE   = 3'd2,
        S_COMPACT = 3'd3,
        S_CLR     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Control registers
    logic [3:0]       count_q, count_d;
    logic [3:0]       idx_q, idx_d;        // search index i / compaction index j
    logic [ID_W-1:0]  add_id_q, add_id_d;  // latched add ID, or the cancelled entry's ID
    logic [QTY_W-1:0] add_qty_q, add_qty_d;
    logic             merge_q, merge_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;

    // Read-only views of the entry registers
    logic [ID_W-1:0]  entry_id  [MAX_ITEMS];
    logic [QTY_W-1:0] entry_qty [MAX_ITEMS];

    // Entry selected by RdIndex, idx_q and CancelIndex
    logic [ID_W-1:0]  rd_id, sel_id, can_id;
    logic [QTY_W-1:0] rd_qty, sel_qty, can_qty;

    // Command decode
    logic                 cmd_clear, cmd_cancel, cmd_add;
    logic                 cancel_ok, add_ok, full_hit, is_full;
    logic [MAX_ITEMS-1:0] full_match;

    // Merge arithmetic
    logic [QTY_W:0]   merge_sum;
    logic [QTY_W-1:0] merged_qty;
    logic             cmp_last;

    // -------------------------------------------------------------------------
    // Entry selection muxes
    // -------------------------------------------------------------------------
    always_comb begin
        rd_id   = '0;
        rd_qty  = '0;
        sel_id  = '0;
        sel_qty = '0;
        can_id  = '0;
        can_qty = '0;
        for (int k = 0; k < MAX_ITEMS; k++) begin
            if (RdIndex == 4'(k)) begin
                rd_id  = entry_id[k];
                rd_qty = entry_qty[k];
            end
            if (idx_q == 4'(k)) begin
                sel_id  = entry_id[k];
                sel_qty = entry_qty[k];
            end
            if (CancelIndex == 4'(k)) begin
                can_id  = entry_id[k];
                can_qty = entry_qty[k];
            end
        end
    end

    assign is_full    = (count_q == MAX_CNT);
    assign cmd_clear  = Clear;
    assign cmd_cancel = !Clear && Cancel;
    assign cmd_add    = !Clear && !Cancel && Enable;
    assign cancel_ok  = (CancelIndex < count_q);
    assign full_hit   = |full_match;
    // A full basket still accepts an add that will merge, so the Full check
    // looks for the ID across all entries in parallel to reject at T+1.
    assign add_ok     = (ProductQuantity != '0) && (!is_full || full_hit);

    assign merge_sum  = {1'b0, sel_qty} + {1'b0, add_qty_q};
    assign merged_qty = merge_sum[QTY_W] ? QTY_MAX : merge_sum[QTY_W-1:0];
    assign cmp_last   = (idx_q == count_q - 4'd1);

    // -------------------------------------------------------------------------
    // Entry registers
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MAX_ITEMS; gi++) begin : g_entry
            localparam logic [3:0] IDX = 4'(gi);

            logic [ID_W-1:0]  ent_id_q, ent_id_d;
            logic [QTY_W-1:0] ent_qty_q, ent_qty_d;
            logic [ID_W-1:0]  nxt_id;
            logic [QTY_W-1:0] nxt_qty;

            // Neighbour that shifts down into this slot during compaction
            if (gi < MAX_ITEMS - 1) begin : g_nxt
                assign nxt_id  = entry_id[gi+1];
                assign nxt_qty = entry_qty[gi+1];
            end else begin : g_nxt_last
                assign nxt_id  = '0;
                assign nxt_qty = '0;
            end

            assign full_match[gi] = (IDX < count_q) && (ent_id_q == ProductID);
            assign entry_id[gi]   = ent_id_q;
            assign entry_qty[gi]  = ent_qty_q;

            always_comb begin
                ent_id_d  = ent_id_q;
                ent_qty_d = ent_qty_q;
                case (state_q)
                    S_WRITE: begin
                        if (merge_q && (idx_q == IDX)) begin
                            ent_qty_d = merged_qty;
                        end else if (!merge_q && (count_q == IDX)) begin
                            ent_id_d  = add_id_q;
                            ent_qty_d = add_qty_q;
                        end
                    end
                    S_COMPACT: begin
                        if (idx_q == IDX) begin
                            if (cmp_last) begin
                                ent_id_d  = '0;
                                ent_qty_d = '0;
                            end else begin
                                ent_id_d  = nxt_id;
                                ent_qty_d = nxt_qty;
                            end
                        end
                    end
                    S_CLR: begin
                        ent_id_d  = '0;
                        ent_qty_d = '0;
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    ent_id_q  <= '0;
                    ent_qty_q <= '0;
                end else begin
                    ent_id_q  <= ent_id_d;
                    ent_qty_q <= ent_qty_d;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_clear) begin
                    state_d = S_CLR;
                end else if (cmd_cancel) begin
                    state_d = cancel_ok ? S_COMPACT : S_IDLE;
                end else if (cmd_add) begin
                    state_d = add_ok ? S_SEARCH : S_IDLE;
                end
            end
            S_SEARCH: begin
                if (idx_q == count_q) begin
                    state_d = is_full ? S_IDLE : S_WRITE;
                end else if (sel_id == add_id_q) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE:   state_d = S_DONE;
            S_COMPACT: state_d = cmp_last ? S_DONE : S_COMPACT;
            S_CLR:     state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        Busy = (state_q != S_IDLE);
        Done = (state_q == S_DONE);
        Sat  = (state_q == S_DONE) && sat_q;
    end

    assign Err              = err_q;
    assign Full             = is_full;
    assign BasketProductNum = count_q;
    assign RdValid          = (RdIndex < count_q);
    assign RdProductID      = RdValid ? rd_id  : '0;
    assign RdQuantity       = RdValid ? rd_qty : '0;

    // -------------------------------------------------------------------------
    // Control datapath
    // -------------------------------------------------------------------------
    always_comb begin
        count_d   = count_q;
        idx_d     = idx_q;
        add_id_d  = add_id_q;
        add_qty_d = add_qty_q;
        merge_d   = merge_q;
        sat_d     = sat_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d   = '0;
                merge_d = 1'b0;
                sat_d   = 1'b0;
                if (cmd_clear) begin
                    // nothing to latch
                end else if (cmd_cancel) begin
                    if (cancel_ok) begin
                        idx_d     = CancelIndex;
                        // Remember the removed entry so its value can leave the total
                        add_id_d  = can_id;
                        add_qty_d = can_qty;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cmd_add) begin
                    if (add_ok) begin
                        add_id_d  = ProductID;
                        add_qty_d = ProductQuantity;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SEARCH: begin
                if (idx_q == count_q) begin
                    merge_d = 1'b0;
                    err_d   = is_full;
                end else if (sel_id == add_id_q) begin
                    merge_d = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_WRITE: begin
                if (merge_q) begin
                    sat_d = merge_sum[QTY_W];
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            S_COMPACT: begin
                if (cmp_last) begin
                    count_d = count_q - 4'd1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_CLR: begin
                count_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q   <= '0;
            idx_q     <= '0;
            add_id_q  <= '0;
            add_qty_q <= '0;
            merge_q   <= 1'b0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            idx_q     <= idx_d;
            add_id_q  <= add_id_d;
            add_qty_q <= add_qty_d;
            merge_q   <= merge_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Running basket total
    // -------------------------------------------------------------------------
`ifdef BASKET_TOTAL_EN
    function automatic logic [7:0] price_of(input logic [ID_W-1:0] id);
        price_of = 8'(5 * (32'(id) + 32'd1));
    endfunction

    logic [11:0]      total_q, total_d;
    logic [QTY_W-1:0] delta_qty;
    logic [19:0]      term, up;

    // On a merge only the quantity actually added (after clipping) is priced
    assign delta_qty = merge_q ? (merged_qty - sel_qty) : add_qty_q;
    assign term      = 20'(delta_qty) * 20'(price_of(add_id_q));
    assign up        = 20'(total_q) + term;

    always_comb begin
        total_d = total_q;
        case (state_q)
            S_WRITE:   total_d = (up > 20'd4095) ? 12'hFFF : up[11:0];
            S_COMPACT: begin
                if (cmp_last) begin
                    total_d = (20'(total_q) > term) ? 12'(20'(total_q) - term) : 12'd0;
                end
            end
            S_CLR:     total_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign TotalPrice = total_q;
`else
    assign TotalPrice = '0;
`endif

endmodule

// File: doc/basket_controller.md
Name: basket_controller

Overview:
- Sits directly downstream of the sale-terminal state machine. Consumes its product ID, quantity and one-cycle enable pulse, and stores the shopping basket as an ordered list of (ProductID, Quantity) entries.
- Merges repeat purchases of the same product into one entry, supports cancel-by-index for basket edit mode and a full clear.
- Reports the entry count back to the state machine and the interactive selector, and exposes a read port for the VGA/text display.

Parameters:
MAX_ITEMS, 8, basket capacity in entries (1..15)
ID_W, 4, product ID width
QTY_W, 4, quantity width; per-entry quantity saturates at 2^QTY_W-1

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
Enable  in  1  one-cycle add pulse
ProductID  in  ID_W  product to add, sampled with Enable
ProductQuantity  in  QTY_W  quantity to add, sampled with Enable
Cancel  in  1  one-cycle pulse: remove entry CancelIndex
CancelIndex  in  4  entry index to remove
Clear  in  1  one-cycle pulse: empty basket
RdIndex  in  4  display read index
RdProductID  out  ID_W  entry[RdIndex] ID, combinational
RdQuantity  out  QTY_W  entry[RdIndex] quantity, combinational
RdValid  out  1  RdIndex < BasketProductNum
BasketProductNum  out  4  number of valid entries
Busy  out  1  high whenever FSM is not IDLE
Full  out  1  BasketProductNum == MAX_ITEMS
Done  out  1  one-cycle pulse, operation completed
Err  out  1  one-cycle pulse, command rejected
Sat  out  1  one-cycle pulse with Done, merge saturated

Behaviour:
- Reset: all outputs 0. BasketProductNum=0. All entries ID=0, Qty=0. FSM=IDLE.
  - Reset mid-operation aborts immediately; the basket is empty afterwards.
- Command priority in IDLE: Clear > Cancel > Enable. Lower-priority commands in the same cycle are dropped, with no Err.
- Commands arriving while Busy=1 are dropped silently.
- FSM states: IDLE, SEARCH, WRITE, COMPACT, CLR, DONE.
- Add:
  - Enable in IDLE at cycle T latches ID/Qty and sets index i=0; SEARCH starts at T+1.
  - SEARCH, one entry per cycle:
    - if i==count, go WRITE(append);
    - else if entry[i].ID==ID, go WRITE(merge i);
    - else i++.
  - WRITE:
    - merge: Qty_i = min(Qty_i+Qty, 2^QTY_W-1); Sat=1 if clipped.
    - append: entry[count]=(ID,Qty), count++.
  - DONE: Done=1 for one cycle, then IDLE.
  - Latency on an empty basket: Enable at T, Done at T+3, new count visible at T+3.
- Add rejections: both pulse Err at T+1, leave the basket unchanged and return to IDLE.
  - ProductQuantity==0.
  - Append when Full (SEARCH reaches i==count==MAX_ITEMS).
  - A merge into an existing entry is still allowed when Full.
- Cancel:
  - If CancelIndex >= count: Err at T+1, no change.
  - Otherwise go to COMPACT with j=CancelIndex.
    - Each cycle: entry[j]=entry[j+1], j++.
    - When j==count-1: clear entry[count-1], count--, go DONE.
  - Cancelling the last entry takes 1 COMPACT cycle.
- Clear: CLR zeroes count and all entries in one cycle, then DONE.
- Entry order is insertion order, compacted with no holes.
- RdProductID/RdQuantity return 0 when RdValid=0.

Optional Feature:
BASKET_TOTAL_EN
- Defined:
  - Adds an internal price ROM: price(id) = 5*(id+1), 8 bits.
  - Adds output TotalPrice[11:0] = sum of Qty_i * price(ID_i), kept as a running register.
  - Updates in the same WRITE/COMPACT/CLR cycle as the entry change.
  - Saturates at 4095.
  - Merge saturation adds only the quantity actually added.
- Undefined: TotalPrice port still exists, tied to 0; no ROM or multiplier is synthesized.

Test Plan:
- Reset, then Enable ID=3 Qty=2 -> Done 3 cycles later; count=1; Rd[0]=(3,2); with macro, TotalPrice=40.
- Adds (3,2),(5,1),(3,14) -> count=2; Rd[0]=(3,15); Sat pulse on third add; Rd[1]=(5,1).
- Fill with 8 distinct IDs, then add a new ID -> Err, count stays 8, Full=1. Add an existing ID -> accepted, Qty merges.
- Entries A,B,C,D, Cancel index 1 -> basket A,C,D, count=3. Cancel index 3 -> Err, no change.
- Cancel and Enable in the same cycle -> only the cancel is performed. Enable issued while Busy -> dropped, no Err.
- Clear with 5 entries -> count=0 and Done 2 cycles after Clear. Assert RESET_N during SEARCH -> all outputs 0 asynchronously.
